bus_protocol_responder: RTL and testbench



---
 rtl/bus_protocol_responder_if.sv | 21 ++
 rtl/bus_protocol_responder.sv | 118 +++++++++++
 tb/tb_bus_protocol_responder.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/bus_protocol_responder_if.sv
// Request/acknowledge bundle between a requester (master) and the responder (slave).
interface bus_protocol_responder_if;
    logic       i_req;
    logic       i_readWrite_n;
    logic       i_addrStall;
    logic       i_respStall;
    logic       o_addressAck;
    logic       o_readAck;
    logic       o_writeAck;
    logic [2:0] o_pendingCount;

    modport slave (
        input  i_req, i_readWrite_n, i_addrStall, i_respStall,
        output o_addressAck, o_readAck, o_writeAck, o_pendingCount
    );

    modport master (
        output i_req, i_readWrite_n, i_addrStall, i_respStall,
        input  o_addressAck, o_readAck, o_writeAck, o_pendingCount
    );
endinterface

// File: rtl/bus_protocol_responder.sv
// In-order pipelined bus responder: accepts address phases into a small circular
// queue and retires each one with a single read/write ack once its age reaches 0.

// One queue slot: transaction type plus a saturating age down-counter.
module bus_protocol_responder_slot #(
    parameter int RESP_LATENCY = 2
) (
    input  logic       i_clk,
    input  logic       i_arst_n,
    input  logic       wr_en_i,
    input  logic       wr_rd_i,
    output logic       rd_o,
    output logic [3:0] age_o
);
    localparam logic [3:0] AGE_INIT = 4'(RESP_LATENCY - 1);

    logic       rd_q, rd_d;
    logic [3:0] age_q, age_d;

    // Load on accept, otherwise count down and hold at zero.
    always_comb begin
        rd_d  = rd_q;
        age_d = age_q;
        if (wr_en_i) begin
            rd_d  = wr_rd_i;
            age_d = AGE_INIT;
        end else if (age_q != 4'd0) begin
            age_d = age_q - 4'd1;
        end
    end

    // Slot state register.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            rd_q  <= 1'b0;
            age_q <= 4'd0;
        end else begin
            rd_q  <= rd_d;
            age_q <= age_d;
        end
    end

    assign rd_o  = rd_q;
    assign age_o = age_q;
endmodule

module bus_protocol_responder #(
    parameter int PIPE_DEPTH   = 4,
    parameter int RESP_LATENCY = 2
) (
    input  logic                        i_clk,
    input  logic                        i_arst_n,
    bus_protocol_responder_if.slave     bus
);
    localparam int PTR_W = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;
    localparam logic [2:0]       DEPTH_C = 3'(PIPE_DEPTH);
    localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(PIPE_DEPTH - 1);

    logic [2:0]                  count_q, count_d;
    logic [PTR_W-1:0]            head_q, head_d;
    logic [PTR_W-1:0]            tail_q, tail_d;
    logic [PIPE_DEPTH-1:0]       slot_rd;
    logic [PIPE_DEPTH-1:0][3:0]  slot_age;
    logic                        accept;
    logic                        retire;
    logic                        head_rd;

    // Acceptance looks only at the registered count, so a same-cycle retire
    // never opens a slot early and the count cannot exceed PIPE_DEPTH.
    assign accept  = bus.i_req && !bus.i_addrStall && (count_q < DEPTH_C);
    assign retire  = (count_q != 3'd0) && (slot_age[head_q] == 4'd0) && !bus.i_respStall;
    assign head_rd = slot_rd[head_q];

    assign bus.o_addressAck   = accept;
    assign bus.o_readAck      = retire && head_rd;
    assign bus.o_writeAck     = retire && !head_rd;
    assign bus.o_pendingCount = count_q;

    for (genvar g = 0; g < PIPE_DEPTH; g++) begin : g_slot
        bus_protocol_responder_slot #(
            .RESP_LATENCY (RESP_LATENCY)
        ) u_slot (
            .i_clk    (i_clk),
            .i_arst_n (i_arst_n),
            .wr_en_i  (accept && (tail_q == PTR_W'(g))),
            .wr_rd_i  (bus.i_readWrite_n),
            .rd_o     (slot_rd[g]),
            .age_o    (slot_age[g])
        );
    end

    // Pointer advance with wrap at PIPE_DEPTH, and occupancy update.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (retire) head_d = (head_q == LAST_C) ? '0 : head_q + PTR_W'(1);
        if (accept) tail_d = (tail_q == LAST_C) ? '0 : tail_q + PTR_W'(1);
        case ({accept, retire})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
    end

    // Queue control registers; reset drops every outstanding transaction.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 3'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end
endmodule

// File: tb/tb_bus_protocol_responder.sv
// Randomized and directed bench for bus_protocol_responder against a
// transaction-level queue model (each entry carries its due cycle).
module tb_bus_protocol_responder;
    localparam int D = 4;
    localparam int L = 2;

    logic clk = 1'b0;
    logic arst_n = 1'b0;
    always #5 clk = ~clk;

    bus_protocol_responder_if bus();

    bus_protocol_responder #(
        .PIPE_DEPTH   (D),
        .RESP_LATENCY (L)
    ) dut (
        .i_clk    (clk),
        .i_arst_n (arst_n),
        .bus      (bus)
    );

    typedef struct {
        logic rd;
        int   due;
    } txn_t;

    txn_t q[$];
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_err  = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, compare the
    // combinational/registered outputs with the model, then advance the model.
    task automatic step(input logic req, input logic rw, input logic as,
                        input logic rs, output logic acc);
        logic e_acc, e_ret, e_rd, e_wr;
        @(negedge clk);
        bus.i_req         = req;
        bus.i_readWrite_n = rw;
        bus.i_addrStall   = as;
        bus.i_respStall   = rs;
        #1;
        e_acc = req && !as && (q.size() < D);
        e_ret = (q.size() > 0) && !rs && (cyc >= q[0].due);
        e_rd  = e_ret && q[0].rd;
        e_wr  = e_ret && !q[0].rd;
        check("addressAck", int'(bus.o_addressAck), int'(e_acc));
        check("readAck",    int'(bus.o_readAck),    int'(e_rd));
        check("writeAck",   int'(bus.o_writeAck),   int'(e_wr));
        check("pending",    int'(bus.o_pendingCount), q.size());
        if (e_ret) void'(q.pop_front());
        if (e_acc) q.push_back('{rd: rw, due: cyc + L});
        acc = e_acc;
        cyc++;
    endtask

    task automatic idle(input int n);
        logic a;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, a);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic acc, rw, rq, as, rs;
        int   n;

        bus.i_req = 1'b0; bus.i_readWrite_n = 1'b0;
        bus.i_addrStall = 1'b0; bus.i_respStall = 1'b0;

        // Reset state while held in reset.
        #1;
        check("rst_addressAck", int'(bus.o_addressAck), 0);
        check("rst_readAck",    int'(bus.o_readAck), 0);
        check("rst_writeAck",   int'(bus.o_writeAck), 0);
        check("rst_pending",    int'(bus.o_pendingCount), 0);
        @(negedge clk); arst_n = 1'b1;

        idle(10);

        // Single read, then drain.
        step(1'b1, 1'b1, 1'b0, 1'b0, acc);
        check("single_accept", int'(acc), 1);
        idle(5);

        // Fill under response stall with alternating types, then release.
        rw = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, rw, 1'b0, 1'b1, acc);
            if (acc) rw = !rw;
        end
        check("fill_pending", int'(bus.o_pendingCount), D);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, rw, 1'b0, 1'b0, acc);
            if (acc) rw = !rw;
        end
        idle(8);

        // Back-to-back writes wrapping the pointers.
        n = 0;
        for (int i = 0; i < 20 && n < 6; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, acc);
            if (acc) n++;
        end
        check("b2b_accepts", n, 6);
        idle(6);

        // Address stall blocks acceptance, release accepts same cycle.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b1, 1'b0, acc);
        step(1'b1, 1'b1, 1'b0, 1'b0, acc);
        idle(5);

        // Reset with three transactions outstanding.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b1, acc);
        step(1'b0, 1'b0, 1'b0, 1'b1, acc);
        @(negedge clk);
        bus.i_respStall = 1'b0;
        arst_n = 1'b0;
        #1;
        check("midrst_pending",  int'(bus.o_pendingCount), 0);
        check("midrst_readAck",  int'(bus.o_readAck), 0);
        check("midrst_writeAck", int'(bus.o_writeAck), 0);
        q.delete();
        cyc++;
        @(negedge clk); arst_n = 1'b1;
        cyc++;
        idle(20);

        // Random traffic honouring the hold-until-ack requester contract.
        rq = 1'b0; rw = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!rq && $urandom_range(0, 3) != 0) begin
                rq = 1'b1;
                rw = 1'($urandom_range(0, 1));
            end
            as = ($urandom_range(0, 4) == 0);
            rs = ($urandom_range(0, 3) == 0);
            step(rq, rw, as, rs, acc);
            if (acc) rq = 1'b0;
        end
        idle(10);
        check("final_empty", int'(bus.o_pendingCount), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
